trace_capture_buffer: RTL and testbench
=======================================

// Module: trace_capture_buffer
// PURPOSE
//  Synthesizable, parametrised on-chip trace buffer for the multi-cycle core.
//  Samples per-cycle or per-instruction core state (instr, aluout, result, state, zero, carry) into a FIFO.
//  Replaces negedge $display monitoring; supports an opcode-match trigger mode.
//  Sits beside multi_cycle; taps its debug outputs; drained through a read port by a bench or debug host.
// PARAMETERS
//  DATA_W        16     width of instr/aluout/result taps
//  STATE_W       2      width of core state tap
//  DEPTH         16     FIFO entries; power of two, >= 2
//  RETIRE_STATE  2'b00  core state value marking the start of a new instruction (fetch)
//  localparam ENTRY_W = 3*DATA_W + STATE_W + 2; AW = $clog2(DEPTH)
// PORTS
//  clk          in   1        clock; all logic on posedge
//  reset        in   1        synchronous, active-high
//  cfg_mode     in   2        00 off, 01 every cycle, 10 per-instruction, 11 triggered
//  cfg_trig_op  in   4        opcode (instr[DATA_W-1:DATA_W-4]) that fires the trigger in mode 11
//  cfg_clear    in   1        sync clear of FIFO, overflow, trigger FSM
//  instr, aluout, result  in  DATA_W each   core taps
//  state        in   STATE_W  core state tap
//  zero, carry  in   1        core flag taps
//  rd_en        in   1        pop request
//  rd_valid     out  1        rd_data valid (one-cycle pulse)
//  rd_data      out  ENTRY_W  {instr, aluout, result, state, zero, carry}
//  count        out  AW+1     entries held, 0..DEPTH
//  empty, full  out  1        count==0 / count==DEPTH
//  overflow     out  1        sticky: a sample was dropped because FIFO was full
//  triggered    out  1        mode 11: trigger has fired
// BEHAVIOUR
//  Reset or cfg_clear: pointers=0, count=0, empty=1, full=0, overflow=0, triggered=0, rd_valid=0, rd_data=0, FSM=IDLE.
//  sample condition (combinational, this cycle):
//   mode 00: never. mode 01: every cycle.
//   mode 10: state==RETIRE_STATE && prev_state!=RETIRE_STATE; prev_state reg resets to ~RETIRE_STATE.
//   mode 11: the mode-10 condition, gated by the FSM.
//  Trigger FSM (mode 11 only; other modes hold it in IDLE):
//   IDLE    -> ARMED    when cfg_mode==11
//   ARMED   -> CAPTURE  on a sample condition with the opcode field == cfg_trig_op
//                       (that instruction is written, triggered<=1)
//   CAPTURE -> DONE     when a write makes count==DEPTH
//   DONE: no further writes; triggered stays 1.
//   Any state -> IDLE when cfg_mode != 11.
//   Mode 11 never sets overflow (capture stops at full).
//  Write: on a sample condition the entry is written at wr_ptr next edge; wr_ptr wraps DEPTH-1 -> 0.
//   Full without same-cycle pop: sample dropped; overflow<=1 (modes 01/10).
//  Read: rd_en && !empty -> rd_data<=mem[rd_ptr], rd_valid<=1 next cycle, rd_ptr wraps.
//   rd_en while empty: ignored, rd_valid<=0, rd_data holds.
//  Latency: write-to-visible count = 1 cycle; pop-to-rd_data = 1 cycle.
//  Simultaneous write+pop:
//   not empty: both occur, count unchanged.
//   full: pop frees a slot, write accepted, no overflow.
//   empty: pop ignored, write occurs.
//  Priority: reset > cfg_clear > normal operation.
//   Clear mid-capture discards all entries; the same-cycle sample is discarded.
//  Mode change mid-operation keeps FIFO contents.
// TESTING
//  T1 reset: hold reset 2 cycles -> count=0, empty=1, overflow=0, rd_valid=0.
//  T2 mode 01, DEPTH=16:
//   20 cycles -> full=1, overflow=1, count=16.
//   16 pops -> first rd_data = cycle-1 sample, rd_valid high 16 cycles, empty=1.
//  T3 mode 10: program 22a1, 2849 -> exactly 2 entries;
//   entry0 instr=22a1, entry1 instr=2849, state field == RETIRE_STATE.
//  T4 mode 11, cfg_trig_op=4'h2:
//   instr 1xxx then 22a1 -> triggered=1 at 22a1; first entry instr=22a1; no 1xxx entry.
//  T5 full FIFO, sample + rd_en same cycle -> count stays 16, overflow stays 0.
//  T6 cfg_clear while count=5 with a sample the same cycle -> next cycle count=0, empty=1, triggered=0.

Source files
------------

// File: rtl/trace_capture_buffer.sv
// trace_capture_buffer
//   On-chip trace FIFO that sits beside the multi-cycle core and records its
//   debug taps, either every cycle, once per instruction (on entry to the
//   retire/fetch state), or once per instruction after an opcode trigger.
//   Entries are drained through a simple pop port.
//
// Ports
//   clk, reset           clock; synchronous active-high reset
//   cfg_mode             00 off, 01 every cycle, 10 per-instruction, 11 triggered
//   cfg_trig_op          opcode (top 4 instr bits) that fires the trigger
//   cfg_clear            synchronous clear of FIFO, overflow and trigger logic
//   instr/aluout/result  core data taps
//   state, zero, carry   core state and flag taps
//   rd_en                pop request
//   rd_valid, rd_data    popped entry {instr, aluout, result, state, zero, carry}
//   count, empty, full   occupancy
//   overflow             sticky: a sample was dropped while full
//   triggered            trigger has fired (triggered mode)
module trace_capture_buffer #(
  parameter int unsigned         DATA_W       = 16,
  parameter int unsigned         STATE_W      = 2,
  parameter int unsigned         DEPTH        = 16,
  parameter logic [STATE_W-1:0]  RETIRE_STATE = '0,
  localparam int unsigned        ENTRY_W      = 3*DATA_W + STATE_W + 2,
  localparam int unsigned        AW           = $clog2(DEPTH)
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [1:0]         cfg_mode,
  input  logic [3:0]         cfg_trig_op,
  input  logic               cfg_clear,
  input  logic [DATA_W-1:0]  instr,
  input  logic [DATA_W-1:0]  aluout,
  input  logic [DATA_W-1:0]  result,
  input  logic [STATE_W-1:0] state,
  input  logic               zero,
  input  logic               carry,
  input  logic               rd_en,
  output logic               rd_valid,
  output logic [ENTRY_W-1:0] rd_data,
  output logic [AW:0]        count,
  output logic               empty,
  output logic               full,
  output logic               overflow,
  output logic               triggered
);

  localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

  typedef enum logic [1:0] {
    T_IDLE,
    T_ARMED,
    T_CAPTURE,
    T_DONE
  } trig_state_t;

  trig_state_t          fsm;
  logic [ENTRY_W-1:0]   mem [DEPTH];
  logic [AW-1:0]        wr_ptr;
  logic [AW-1:0]        rd_ptr;
  logic [STATE_W-1:0]   prev_state;

  logic                 retire;
  logic                 op_match;
  logic                 sample;
  logic                 pop;
  logic                 push;
  logic [AW:0]          count_next;

  assign empty = (count == '0);
  assign full  = (count == FULL_CNT);

  always_comb begin
    retire   = (state == RETIRE_STATE) && (prev_state != RETIRE_STATE);
    op_match = (instr[DATA_W-1 -: 4] == cfg_trig_op);
    sample   = 1'b0;
    case (cfg_mode)
      2'b01:   sample = 1'b1;
      2'b10:   sample = retire;
      // First matching instruction while armed, then every instruction until full.
      2'b11:   sample = retire && (((fsm == T_ARMED) && op_match) || (fsm == T_CAPTURE));
      default: sample = 1'b0;
    endcase
    pop        = rd_en && !empty;
    // A same-cycle pop frees the slot the write needs when full.
    push       = sample && (!full || pop);
    count_next = count + {{AW{1'b0}}, push} - {{AW{1'b0}}, pop};
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      count      <= '0;
      overflow   <= 1'b0;
      triggered  <= 1'b0;
      rd_valid   <= 1'b0;
      rd_data    <= '0;
      fsm        <= T_IDLE;
      prev_state <= ~RETIRE_STATE;
    end else begin
      prev_state <= state;
      if (cfg_clear) begin
        wr_ptr    <= '0;
        rd_ptr    <= '0;
        count     <= '0;
        overflow  <= 1'b0;
        triggered <= 1'b0;
        rd_valid  <= 1'b0;
        rd_data   <= '0;
        fsm       <= T_IDLE;
      end else begin
        if (push) wr_ptr <= wr_ptr + 1'b1;
        if (pop) begin
          rd_ptr  <= rd_ptr + 1'b1;
          rd_data <= mem[rd_ptr];
        end
        rd_valid <= pop;
        count    <= count_next;
        // Triggered mode stops at full rather than reporting loss.
        if (sample && !push && (cfg_mode != 2'b11)) overflow <= 1'b1;
        if (cfg_mode != 2'b11) begin
          fsm <= T_IDLE;
        end else begin
          case (fsm)
            T_IDLE:  fsm <= T_ARMED;
            T_ARMED: begin
              if (sample) begin
                triggered <= 1'b1;
                fsm       <= (push && (count_next == FULL_CNT)) ? T_DONE : T_CAPTURE;
              end
            end
            T_CAPTURE: begin
              if (push && (count_next == FULL_CNT)) fsm <= T_DONE;
            end
            default: fsm <= T_DONE;
          endcase
        end
      end
    end
  end

  // Storage needs no reset; occupancy is tracked by the pointers and count.
  always_ff @(posedge clk) begin
    if (!reset && !cfg_clear && push) begin
      mem[wr_ptr] <= {instr, aluout, result, state, zero, carry};
    end
  end

endmodule

// File: tb/tb_trace_capture_buffer.sv
module tb_trace_capture_buffer;
  localparam int DEPTH   = 16;
  localparam int ENTRY_W = 52;

  logic               clk = 1'b0;
  logic               reset;
  logic [1:0]         cfg_mode;
  logic [3:0]         cfg_trig_op;
  logic               cfg_clear;
  logic [15:0]        instr, aluout, result;
  logic [1:0]         state;
  logic               zero, carry;
  logic               rd_en;
  logic               rd_valid;
  logic [ENTRY_W-1:0] rd_data;
  logic [4:0]         count;
  logic               empty, full, overflow, triggered;

  trace_capture_buffer #(
    .DATA_W(16),
    .STATE_W(2),
    .DEPTH(DEPTH),
    .RETIRE_STATE(2'b00)
  ) dut (
    .clk(clk), .reset(reset), .cfg_mode(cfg_mode), .cfg_trig_op(cfg_trig_op),
    .cfg_clear(cfg_clear), .instr(instr), .aluout(aluout), .result(result),
    .state(state), .zero(zero), .carry(carry), .rd_en(rd_en),
    .rd_valid(rd_valid), .rd_data(rd_data), .count(count), .empty(empty),
    .full(full), .overflow(overflow), .triggered(triggered)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model: FIFO as a queue plus a few phase flags.
  logic [ENTRY_W-1:0] q[$];
  logic               m_ovf, m_trig, m_rdv;
  logic [ENTRY_W-1:0] m_rdd;
  logic [1:0]         m_prev;
  bit                 m_armed, m_fired, m_done;

  task automatic drive(input logic [1:0] st, input logic [15:0] ins);
    state  = st;
    instr  = ins;
    aluout = 16'($urandom);
    result = 16'($urandom);
    zero   = 1'($urandom);
    carry  = 1'($urandom);
  endtask

  // Advance one clock and update the model from the inputs held across that edge.
  task automatic step();
    logic [ENTRY_W-1:0] e;
    bit retire, samp, pop, acc;
    @(posedge clk);
    e      = {instr, aluout, result, state, zero, carry};
    retire = (state == 2'b00) && (m_prev != 2'b00);
    if (reset) begin
      q.delete();
      m_ovf = 0; m_trig = 0; m_rdv = 0; m_rdd = '0; m_prev = 2'b11;
      m_armed = 0; m_fired = 0; m_done = 0;
    end else begin
      if (cfg_clear) begin
        q.delete();
        m_ovf = 0; m_trig = 0; m_rdv = 0; m_rdd = '0;
        m_armed = 0; m_fired = 0; m_done = 0;
      end else begin
        case (cfg_mode)
          2'd1:    samp = 1;
          2'd2:    samp = retire;
          2'd3:    samp = retire && m_armed && !m_done && (m_fired || instr[15:12] == cfg_trig_op);
          default: samp = 0;
        endcase
        pop   = rd_en && (q.size() > 0);
        acc   = samp && ((q.size() < DEPTH) || pop);
        m_rdv = pop;
        if (pop) m_rdd = q.pop_front();
        if (acc) q.push_back(e);
        if (samp && !acc && cfg_mode != 2'd3) m_ovf = 1;
        if (cfg_mode != 2'd3) begin
          m_armed = 0; m_fired = 0; m_done = 0;
        end else if (!m_armed) begin
          m_armed = 1;
        end else if (samp) begin
          m_fired = 1;
          m_trig  = 1;
          if (acc && q.size() == DEPTH) m_done = 1;
        end
      end
      m_prev = state;
    end
    #1;
  endtask

  task automatic do_clear(input logic [1:0] mode);
    cfg_mode  = mode;
    cfg_clear = 1;
    rd_en     = 0;
    drive(2'd1, 16'h0000);
    step();
    cfg_clear = 0;
  endtask

  task automatic test_reset();
    reset = 1; cfg_mode = 2'd1; cfg_trig_op = 4'h0; cfg_clear = 0; rd_en = 1;
    drive(2'd0, 16'h1234);
    step();
    step();
    n_checks++; if (count !== 5'd0) begin n_fail++; $display("FAIL reset_count: got %0d expected 0", count); end
    n_checks++; if (empty !== 1'b1) begin n_fail++; $display("FAIL reset_empty: got %b expected 1", empty); end
    n_checks++; if (overflow !== 1'b0) begin n_fail++; $display("FAIL reset_overflow: got %b expected 0", overflow); end
    n_checks++; if (rd_valid !== 1'b0) begin n_fail++; $display("FAIL reset_rd_valid: got %b expected 0", rd_valid); end
    n_checks++; if (triggered !== 1'b0 || full !== 1'b0) begin n_fail++; $display("FAIL reset_trig_full: got %b%b expected 00", triggered, full); end
    reset = 0; rd_en = 0; cfg_mode = 2'd0;
    step();
  endtask

  task automatic test_every_cycle();
    logic [ENTRY_W-1:0] e0;
    do_clear(2'd0);
    cfg_mode = 2'd1;
    for (int i = 0; i < 20; i++) begin
      drive(2'($urandom), 16'($urandom));
      if (i == 0) e0 = {instr, aluout, result, state, zero, carry};
      step();
    end
    n_checks++; if (full !== 1'b1) begin n_fail++; $display("FAIL ec_full: got %b expected 1", full); end
    n_checks++; if (overflow !== 1'b1) begin n_fail++; $display("FAIL ec_overflow: got %b expected 1", overflow); end
    n_checks++; if (count !== 5'd16) begin n_fail++; $display("FAIL ec_count: got %0d expected 16", count); end
    cfg_mode = 2'd0;
    rd_en    = 1;
    for (int i = 0; i < 16; i++) begin
      step();
      n_checks++; if (rd_valid !== 1'b1) begin n_fail++; $display("FAIL ec_rd_valid[%0d]: got %b expected 1", i, rd_valid); end
      if (i == 0) begin
        n_checks++; if (rd_data !== e0) begin n_fail++; $display("FAIL ec_first_entry: got %h expected %h", rd_data, e0); end
      end
      n_checks++; if (rd_data !== m_rdd) begin n_fail++; $display("FAIL ec_rd_data[%0d]: got %h expected %h", i, rd_data, m_rdd); end
    end
    rd_en = 0;
    step();
    n_checks++; if (empty !== 1'b1 || rd_valid !== 1'b0) begin n_fail++; $display("FAIL ec_drained: got empty=%b rd_valid=%b expected 1 0", empty, rd_valid); end
  endtask

  task automatic test_per_instr();
    logic [1:0]  sts [7] = '{2'd0, 2'd1, 2'd2, 2'd0, 2'd1, 2'd2, 2'd1};
    logic [15:0] ins [7] = '{16'h22a1, 16'h22a1, 16'h22a1, 16'h2849, 16'h2849, 16'h2849, 16'h0000};
    do_clear(2'd2);
    for (int i = 0; i < 7; i++) begin
      drive(sts[i], ins[i]);
      step();
    end
    n_checks++; if (count !== 5'd2) begin n_fail++; $display("FAIL pi_count: got %0d expected 2", count); end
    cfg_mode = 2'd0;
    rd_en    = 1;
    step();
    n_checks++; if (rd_data[51:36] !== 16'h22a1) begin n_fail++; $display("FAIL pi_entry0: got %h expected 22a1", rd_data[51:36]); end
    n_checks++; if (rd_data[3:2] !== 2'b00) begin n_fail++; $display("FAIL pi_state: got %b expected 00", rd_data[3:2]); end
    step();
    n_checks++; if (rd_data[51:36] !== 16'h2849) begin n_fail++; $display("FAIL pi_entry1: got %h expected 2849", rd_data[51:36]); end
    n_checks++; if (rd_data !== m_rdd) begin n_fail++; $display("FAIL pi_entry1_full: got %h expected %h", rd_data, m_rdd); end
    rd_en = 0;
    step();
  endtask

  task automatic test_trigger();
    cfg_trig_op = 4'h2;
    do_clear(2'd3);
    drive(2'd1, 16'h1000);
    step();
    drive(2'd0, 16'h1abc); step();
    drive(2'd1, 16'h1abc); step();
    drive(2'd2, 16'h1abc); step();
    n_checks++; if (count !== 5'd0 || triggered !== 1'b0) begin n_fail++; $display("FAIL tr_no_early: got count=%0d trig=%b expected 0 0", count, triggered); end
    drive(2'd0, 16'h22a1);
    step();
    n_checks++; if (triggered !== 1'b1) begin n_fail++; $display("FAIL tr_fired: got %b expected 1", triggered); end
    n_checks++; if (count !== 5'd1) begin n_fail++; $display("FAIL tr_count: got %0d expected 1", count); end
    rd_en = 1;
    drive(2'd1, 16'h3000);
    step();
    rd_en = 0;
    n_checks++; if (rd_data[51:36] !== 16'h22a1) begin n_fail++; $display("FAIL tr_first_entry: got %h expected 22a1", rd_data[51:36]); end
    for (int i = 0; i < 40; i++) begin
      drive((i % 2 == 0) ? 2'd0 : 2'd1, 16'($urandom));
      step();
    end
    n_checks++; if (count !== 5'd16 || int'(count) !== q.size()) begin n_fail++; $display("FAIL tr_cap_count: got %0d expected 16", count); end
    n_checks++; if (overflow !== 1'b0) begin n_fail++; $display("FAIL tr_no_overflow: got %b expected 0", overflow); end
    n_checks++; if (triggered !== 1'b1) begin n_fail++; $display("FAIL tr_sticky: got %b expected 1", triggered); end
    cfg_mode = 2'd0;
    step();
  endtask

  task automatic test_full_pop();
    do_clear(2'd1);
    for (int i = 0; i < 16; i++) begin
      drive(2'($urandom), 16'($urandom));
      step();
    end
    n_checks++; if (full !== 1'b1 || overflow !== 1'b0) begin n_fail++; $display("FAIL fp_prefill: got full=%b ovf=%b expected 1 0", full, overflow); end
    rd_en = 1;
    drive(2'd1, 16'hbeef);
    step();
    rd_en    = 0;
    cfg_mode = 2'd0;
    n_checks++; if (count !== 5'd16) begin n_fail++; $display("FAIL fp_count: got %0d expected 16", count); end
    n_checks++; if (overflow !== 1'b0) begin n_fail++; $display("FAIL fp_overflow: got %b expected 0", overflow); end
    n_checks++; if (rd_valid !== 1'b1 || rd_data !== m_rdd) begin n_fail++; $display("FAIL fp_rd: got %b/%h expected 1/%h", rd_valid, rd_data, m_rdd); end
    step();
  endtask

  task automatic test_clear();
    cfg_trig_op = 4'h2;
    do_clear(2'd3);
    drive(2'd1, 16'h0000); step();
    drive(2'd0, 16'h2abc); step();
    for (int i = 0; i < 4; i++) begin
      drive(2'd1, 16'($urandom)); step();
      drive(2'd0, 16'($urandom)); step();
    end
    n_checks++; if (count !== 5'd5 || triggered !== 1'b1) begin n_fail++; $display("FAIL cl_before: got count=%0d trig=%b expected 5 1", count, triggered); end
    drive(2'd1, 16'h0000); step();
    cfg_clear = 1;
    drive(2'd0, 16'h2000);
    step();
    cfg_clear = 0;
    n_checks++; if (count !== 5'd0 || empty !== 1'b1) begin n_fail++; $display("FAIL cl_count: got count=%0d empty=%b expected 0 1", count, empty); end
    n_checks++; if (triggered !== 1'b0) begin n_fail++; $display("FAIL cl_trig: got %b expected 0", triggered); end
    cfg_mode = 2'd0;
    step();
  endtask

  task automatic test_random();
    cfg_trig_op = 4'($urandom_range(0, 3));
    for (int i = 0; i < 500; i++) begin
      if ($urandom_range(0, 15) == 0) cfg_mode = 2'($urandom_range(0, 3));
      cfg_clear = ($urandom_range(0, 63) == 0);
      rd_en     = ($urandom_range(0, 2) == 0);
      drive(2'($urandom), {2'b00, 2'($urandom_range(0, 3)), 12'($urandom)});
      step();
      n_checks++; if (int'(count) !== q.size()) begin n_fail++; $display("FAIL rnd_count[%0d]: got %0d expected %0d", i, count, q.size()); end
      n_checks++; if (empty !== (q.size() == 0) || full !== (q.size() == DEPTH)) begin n_fail++; $display("FAIL rnd_flags[%0d]: got e=%b f=%b", i, empty, full); end
      n_checks++; if (overflow !== m_ovf) begin n_fail++; $display("FAIL rnd_overflow[%0d]: got %b expected %b", i, overflow, m_ovf); end
      n_checks++; if (triggered !== m_trig) begin n_fail++; $display("FAIL rnd_triggered[%0d]: got %b expected %b", i, triggered, m_trig); end
      n_checks++; if (rd_valid !== m_rdv || rd_data !== m_rdd) begin n_fail++; $display("FAIL rnd_rd[%0d]: got %b/%h expected %b/%h", i, rd_valid, rd_data, m_rdv, m_rdd); end
    end
    cfg_clear = 0;
    rd_en     = 0;
  endtask

  initial begin
    test_reset();
    test_every_cycle();
    test_per_instr();
    test_trigger();
    test_full_pop();
    test_clear();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
